// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter
// Shares one line-transfer unit between the I-cache and the D-cache.
// Each cache raises a level request and holds it until it sees its ack
// pulse. A four-state FSM (IDLE, BUSY, RESP, RELEASE) grants one requester
// at a time. When both caches are waiting, round-robin on the last grant
// picks the winner. The granted request is forwarded with the low 6 address
// bits cleared, so the unit always sees a 64-byte line address. The returned
// line is latched into the requester's rdata register. The ack pulse goes out
// one cycle after the unit's ack.

module cache_axi_arbiter #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_ic_req,
    input  logic [ADDR_W-1:0] i_ic_addr,
    output logic [LINE_W-1:0] o_ic_rdata,
    output logic              o_ic_ack,

    input  logic              i_dc_req,
    input  logic [ADDR_W-1:0] i_dc_addr,
    input  logic              i_dc_op,
    input  logic [LINE_W-1:0] i_dc_wdata,
    output logic [LINE_W-1:0] o_dc_rdata,
    output logic              o_dc_ack,

    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_op,
    output logic [LINE_W-1:0] o_mem_wdata,
    input  logic [LINE_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    // Byte offset within a 64-byte cache line; these bits are cleared on the
    // forwarded address.
    localparam int OFFSET_W = 6;

    // Grant encoding: 0 selects the I-cache, 1 selects the D-cache.
    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Keeps the line-address bits and clears the byte offset.
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t            state;
    logic              grant;
    logic              last;
    logic              mem_req_q;
    logic              ic_ack_q;
    logic              dc_ack_q;
    logic [LINE_W-1:0] ic_rdata_q;
    logic [LINE_W-1:0] dc_rdata_q;

    logic              pick;
    logic              granted_req;

    // Arbitration: a lone requester wins outright. When both are waiting,
    // the one that was not served last time wins.
    // NOTE: every signal assigned in always_comb gets a default on the first
    // line, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick = GRANT_IC;
        if (i_ic_req && i_dc_req) begin
            pick = ~last;
        end else if (i_dc_req) begin
            pick = GRANT_DC;
        end
    end

    // Level of the currently granted requester's req. RELEASE uses it to
    // wait for the handshake to close.
    always_comb begin
        granted_req = (grant == GRANT_DC) ? i_dc_req : i_ic_req;
    end

    // Forwarded transfer fields follow the granted requester combinationally.
    // The I-cache only reads, so its op is always 0 and its write line is 0.
    always_comb begin
        o_mem_addr  = i_ic_addr & LINE_MASK;
        o_mem_op    = 1'b0;
        o_mem_wdata = '0;
        if (grant == GRANT_DC) begin
            o_mem_addr  = i_dc_addr & LINE_MASK;
            o_mem_op    = i_dc_op;
            o_mem_wdata = i_dc_wdata;
        end
    end

    // Arbiter FSM. It also registers mem_req, both acks and both rdata lines.
    // A synchronous reset drops any transfer in flight at once.
    // NOTE: state registers use non-blocking assignments, so every branch
    // reads the values from before this edge and the order of the
    // statements cannot change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GRANT_IC;
            last       <= GRANT_DC;
            mem_req_q  <= 1'b0;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_ic_req || i_dc_req) begin
                        grant     <= pick;
                        mem_req_q <= 1'b1;
                        state     <= BUSY;
                    end
                end

                BUSY: begin
                    // The transfer runs to completion even if the requester
                    // drops req part-way through.
                    if (i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (grant == GRANT_DC) begin
                            dc_rdata_q <= i_mem_rdata;
                        end else begin
                            ic_rdata_q <= i_mem_rdata;
                        end
                        ic_ack_q <= (grant == GRANT_IC);
                        dc_ack_q <= (grant == GRANT_DC);
                        state    <= RESP;
                    end
                end

                RESP: begin
                    ic_ack_q <= 1'b0;
                    dc_ack_q <= 1'b0;
                    last     <= grant;
                    state    <= RELEASE;
                end

                RELEASE: begin
                    // Wait for the served requester to drop req, so a
                    // request still held from the old handshake cannot
                    // start a new transfer.
                    if (!granted_req) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                    ic_ack_q  <= 1'b0;
                    dc_ack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req  = mem_req_q;
    assign o_ic_ack   = ic_ack_q;
    assign o_dc_ack   = dc_ack_q;
    assign o_ic_rdata = ic_rdata_q;
    assign o_dc_rdata = dc_rdata_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter
// Directed bench for cache_axi_arbiter. The bench plays the transfer unit
// itself. Each completion it issues is pushed to a scoreboard queue. The
// entry is popped and compared when the requester's ack should appear.

module tb_cache_axi_arbiter;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_ic_req;
    logic [ADDR_W-1:0] i_ic_addr;
    logic [LINE_W-1:0] o_ic_rdata;
    logic              o_ic_ack;
    logic              i_dc_req;
    logic [ADDR_W-1:0] i_dc_addr;
    logic              i_dc_op;
    logic [LINE_W-1:0] i_dc_wdata;
    logic [LINE_W-1:0] o_dc_rdata;
    logic              o_dc_ack;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_op;
    logic [LINE_W-1:0] o_mem_wdata;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_ack;

    typedef struct packed {
        logic              who;   // 0 = I-cache, 1 = D-cache
        logic [LINE_W-1:0] data;
    } sb_t;

    sb_t               sb[$];
    int                checks = 0;
    int                errors = 0;
    logic [LINE_W-1:0] ic_exp;
    logic [LINE_W-1:0] dc_exp;

    cache_axi_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_ic_req    (i_ic_req),
        .i_ic_addr   (i_ic_addr),
        .o_ic_rdata  (o_ic_rdata),
        .o_ic_ack    (o_ic_ack),
        .i_dc_req    (i_dc_req),
        .i_dc_addr   (i_dc_addr),
        .i_dc_op     (i_dc_op),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_rdata  (o_dc_rdata),
        .o_dc_ack    (o_dc_ack),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_op    (o_mem_op),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] seed);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[i*32 +: 32] = seed ^ (32'(i) * 32'h0101_0101);
        end
        return l;
    endfunction

    // Outputs that must hold whenever no transfer is in flight.
    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"},  o_mem_req,  1'b0);
        chk({tag, "_ic_ack"},   o_ic_ack,   1'b0);
        chk({tag, "_dc_ack"},   o_dc_ack,   1'b0);
        chk({tag, "_ic_rdata"}, o_ic_rdata, ic_exp);
        chk({tag, "_dc_rdata"}, o_dc_rdata, dc_exp);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        ic_exp = '0;
        dc_exp = '0;
        chk_quiet("reset");
        rst = 1'b0;
        step();
    endtask

    // Waits for o_mem_req within a cycle budget and returns the cycles taken.
    task automatic wait_mem_req(input int bound, output int lat);
        lat = 0;
        while (!o_mem_req && lat < bound) begin
            step();
            lat++;
        end
        chk("mem_req_seen", o_mem_req, 1'b1);
    endtask

    // Serves one transfer as the transfer unit. who: 0 = I-cache, 1 = D-cache.
    // drop_mode: 0 keeps req, 1 drops it after the ack, 2 drops it in BUSY.
    // exp_lat: required cycles from the caller's current cycle to o_mem_req;
    // 0 skips this check.
    task automatic transfer(input logic who, input int delay, input logic [LINE_W-1:0] data,
                            input int drop_mode, input int exp_lat, input logic [ADDR_W-1:0] exp_addr);
        int   lat;
        logic exp_op;
        sb_t  e;
        exp_op = who ? i_dc_op : 1'b0;
        wait_mem_req(8, lat);
        if (exp_lat > 0) chk("req_latency", lat, exp_lat);
        chk("mem_addr", o_mem_addr, exp_addr);
        chk("mem_op", o_mem_op, exp_op);
        if (who) chk("mem_wdata", o_mem_wdata, i_dc_wdata);
        if (drop_mode == 2) begin
            if (who) i_dc_req = 1'b0;
            else     i_ic_req = 1'b0;
        end
        for (int i = 0; i < delay; i++) begin
            step();
            chk("busy_mem_req", o_mem_req, 1'b1);
            chk("busy_ic_ack", o_ic_ack, 1'b0);
            chk("busy_dc_ack", o_dc_ack, 1'b0);
            chk("busy_mem_addr", o_mem_addr, exp_addr);
            if (who) chk("busy_mem_wdata", o_mem_wdata, i_dc_wdata);
        end
        i_mem_rdata = data;
        i_mem_ack   = 1'b1;
        e.who  = who;
        e.data = data;
        sb.push_back(e);
        step();
        i_mem_ack   = 1'b0;
        i_mem_rdata = ~data;
        chk("sb_nonempty", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.who) dc_exp = e.data;
            else       ic_exp = e.data;
            chk("resp_ic_ack", o_ic_ack, !e.who);
            chk("resp_dc_ack", o_dc_ack, e.who);
        end
        chk("resp_mem_req", o_mem_req, 1'b0);
        chk("resp_ic_rdata", o_ic_rdata, ic_exp);
        chk("resp_dc_rdata", o_dc_rdata, dc_exp);
        if (drop_mode == 1) begin
            if (who) i_dc_req = 1'b0;
            else     i_ic_req = 1'b0;
        end
        step();
        chk("pulse_ic_ack", o_ic_ack, 1'b0);
        chk("pulse_dc_ack", o_dc_ack, 1'b0);
        chk("post_rdata_ic", o_ic_rdata, ic_exp);
        chk("post_rdata_dc", o_dc_rdata, dc_exp);
    endtask

    initial begin
        int lat;
        rst         = 1'b1;
        i_ic_req    = 1'b0;
        i_ic_addr   = '0;
        i_dc_req    = 1'b0;
        i_dc_addr   = '0;
        i_dc_op     = 1'b0;
        i_dc_wdata  = '0;
        i_mem_rdata = '0;
        i_mem_ack   = 1'b0;
        ic_exp      = '0;
        dc_exp      = '0;
        step();
        apply_reset();

        // I-cache alone: offset bits cleared, op 0, ack 1 cycle after mem ack.
        i_ic_addr = 64'h0000_0000_8000_0047;
        i_ic_req  = 1'b1;
        transfer(1'b0, 5, make_line(32'hA5A5_0001), 1, 1, 64'h0000_0000_8000_0040);

        // Simultaneous pair after reset: the I-cache wins the first tie. The
        // D-cache inputs show op 1, but the forwarded op stays 0 while the
        // I-cache is granted.
        apply_reset();
        i_ic_addr  = 64'h0000_0000_1000_0013;
        i_dc_addr  = 64'h0000_0000_2000_00FF;
        i_dc_op    = 1'b1;
        i_dc_wdata = make_line(32'h1111_2222);
        i_ic_req   = 1'b1;
        i_dc_req   = 1'b1;
        transfer(1'b0, 2, make_line(32'h3333_0001), 1, 1, 64'h0000_0000_1000_0000);
        transfer(1'b1, 2, make_line(32'h3333_0002), 1, 0, 64'h0000_0000_2000_00C0);
        step();

        // Second pair with last = D-cache: the I-cache goes first again.
        i_dc_op  = 1'b0;
        i_ic_req = 1'b1;
        i_dc_req = 1'b1;
        transfer(1'b0, 1, make_line(32'h4444_0001), 1, 1, 64'h0000_0000_1000_0000);
        transfer(1'b1, 1, make_line(32'h4444_0002), 1, 0, 64'h0000_0000_2000_00C0);
        step();

        // I-cache alone, which sets last = I-cache.
        i_ic_req = 1'b1;
        transfer(1'b0, 1, make_line(32'h5555_0001), 1, 1, 64'h0000_0000_1000_0000);
        step();

        // Pair with last = I-cache: the D-cache goes first with a write,
        // op 1, wdata B, addr 0x100. The I-cache is served afterwards.
        i_dc_addr  = 64'h0000_0000_0000_0100;
        i_dc_op    = 1'b1;
        i_dc_wdata = make_line(32'hBBBB_0000);
        i_ic_req   = 1'b1;
        i_dc_req   = 1'b1;
        transfer(1'b1, 3, make_line(32'h6666_0001), 1, 1, 64'h0000_0000_0000_0100);
        transfer(1'b0, 1, make_line(32'h6666_0002), 1, 0, 64'h0000_0000_1000_0000);
        step();

        // Req held 3 cycles after the ack: no new o_mem_req until req drops.
        i_ic_req = 1'b1;
        transfer(1'b0, 2, make_line(32'h7777_0001), 0, 1, 64'h0000_0000_1000_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_quiet("held_req");
        end
        i_ic_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_quiet("after_drop");
        end

        // D-cache drops req in BUSY: the transfer completes and is acked.
        i_dc_op  = 1'b0;
        i_dc_req = 1'b1;
        transfer(1'b1, 3, make_line(32'h8888_0001), 2, 1, 64'h0000_0000_0000_0100);
        step();
        chk_quiet("early_drop_idle");

        // Spurious mem ack in IDLE is ignored.
        i_mem_rdata = make_line(32'hDEAD_0001);
        i_mem_ack   = 1'b1;
        step();
        i_mem_ack = 1'b0;
        chk_quiet("spurious_ack");
        step();
        chk_quiet("spurious_ack_later");

        // Reset in BUSY abandons the transfer. A later mem ack is ignored.
        i_ic_addr = 64'h0000_0000_9000_0001;
        i_ic_req  = 1'b1;
        wait_mem_req(8, lat);
        chk("rst_busy_latency", lat, 1);
        rst = 1'b1;
        step();
        ic_exp = '0;
        dc_exp = '0;
        chk_quiet("rst_in_busy");
        rst      = 1'b0;
        i_ic_req = 1'b0;
        step();
        i_mem_rdata = make_line(32'hDEAD_0002);
        i_mem_ack   = 1'b1;
        step();
        i_mem_ack = 1'b0;
        chk_quiet("ack_after_rst");
        step();
        chk_quiet("ack_after_rst_later");
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
